uart_program_loader: RTL



---
 rtl/uart_program_loader_pkg.sv | 35 +++
 rtl/uart_rx.sv | 110 +++++++++++
 rtl/uart_tx.sv | 95 +++++++++
 rtl/uart_program_loader.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/uart_program_loader_pkg.sv
// Shared constants and state encodings for the UART program loader and its serial helpers.
package uart_program_loader_pkg;

    localparam logic [7:0] CMD_WR_BASE = 8'h80;
    localparam logic [7:0] CMD_HOLD    = 8'h48;
    localparam logic [7:0] CMD_RUN     = 8'h52;
    localparam logic [7:0] ACK         = 8'h06;
    localparam logic [7:0] NAK         = 8'h15;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    typedef enum logic {
        P_CMD,
        P_DATA
    } proto_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Write commands occupy 0x80-0x8F: upper nibble matches the base.
    function automatic logic is_wr_cmd(input logic [7:0] b);
        return b[7:4] == CMD_WR_BASE[7:4];
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, centre sampling, framing-error detection.
module uart_rx
    import uart_program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_ferr
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);

    logic            r_sync1, r_sync2;
    rx_state_t       r_state, w_state_n;
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic [2:0]      r_bit, w_bit_n;
    logic [7:0]      r_shift, w_shift_n;
    logic            r_valid, w_valid_n;
    logic            r_ferr, w_ferr_n;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_valid <= w_valid_n;
            r_ferr  <= w_ferr_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_valid_n = 1'b0;
        w_ferr_n  = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (!r_sync2) begin
                    w_state_n = RX_START;
                    w_cnt_n   = '0;
                end
            end
            RX_START: begin
                if (r_cnt == CW'(HALF - 1)) begin
                    w_cnt_n   = '0;
                    w_bit_n   = '0;
                    w_state_n = r_sync2 ? RX_IDLE : RX_DATA;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    w_cnt_n   = '0;
                    w_shift_n = {r_sync2, r_shift[7:1]};
                    w_bit_n   = r_bit + 1'b1;
                    if (r_bit == 3'd7) begin
                        w_state_n = RX_STOP;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    w_cnt_n = '0;
                    if (r_sync2) begin
                        w_valid_n = 1'b1;
                        w_state_n = RX_IDLE;
                    end else begin
                        w_ferr_n  = 1'b1;
                        w_state_n = RX_WAIT_IDLE;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            RX_WAIT_IDLE: begin
                if (r_sync2) begin
                    w_state_n = RX_IDLE;
                end
            end
            default: w_state_n = RX_IDLE;
        endcase
    end

    assign o_byte  = r_shift;
    assign o_valid = r_valid;
    assign o_ferr  = r_ferr;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; start requests arriving while a byte is in flight are ignored.
// Only built when UART_LOADER_ECHO_EN is defined.
`ifdef UART_LOADER_ECHO_EN
module uart_tx
    import uart_program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_tx
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    tx_state_t     r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [2:0]    r_bit, w_bit_n;
    logic [7:0]    r_shift, w_shift_n;
    logic          r_tx, w_tx_n;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_tx    <= w_tx_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_tx_n    = r_tx;
        case (r_state)
            TX_IDLE: begin
                w_tx_n = 1'b1;
                if (i_start) begin
                    w_shift_n = i_byte;
                    w_cnt_n   = '0;
                    w_tx_n    = 1'b0;
                    w_state_n = TX_START;
                end
            end
            TX_START: begin
                if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    w_cnt_n   = '0;
                    w_bit_n   = '0;
                    w_tx_n    = r_shift[0];
                    w_state_n = TX_DATA;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    w_cnt_n = '0;
                    if (r_bit == 3'd7) begin
                        w_tx_n    = 1'b1;
                        w_state_n = TX_STOP;
                    end else begin
                        w_bit_n   = r_bit + 1'b1;
                        w_shift_n = r_shift >> 1;
                        w_tx_n    = r_shift[1];
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    w_cnt_n   = '0;
                    w_state_n = TX_IDLE;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
        endcase
    end

    assign o_tx = r_tx;

endmodule
`endif

// File: rtl/uart_program_loader.sv
// Loads the program RAM from UART commands and holds the CPU while loading.
// Optional ACK/NAK echo on usb_tx when UART_LOADER_ECHO_EN is defined.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 115_200,
    parameter int ADDR_WIDTH   = 4,
    parameter int TIMEOUT_CLKS = 10 * (CLK_HZ / BAUD) * 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  usb_rx,
    output logic                  usb_tx,
    output logic                  prog_we,
    output logic [ADDR_WIDTH-1:0] prog_addr,
    output logic [7:0]            prog_data,
    output logic                  cpu_hold,
    output logic                  err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TW           = $clog2(TIMEOUT_CLKS + 1);

    logic [7:0]            w_rx_byte;
    logic                  w_rx_valid;
    logic                  w_rx_ferr;

    proto_state_t          r_state, w_state_n;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
    logic [TW-1:0]         r_tmo, w_tmo_n;
    logic                  r_prog_we, w_prog_we_n;
    logic [ADDR_WIDTH-1:0] r_prog_addr, w_prog_addr_n;
    logic [7:0]            r_prog_data, w_prog_data_n;
    logic                  r_hold, w_hold_n;
    logic                  r_err, w_err_n;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_rx   (usb_rx),
        .o_byte (w_rx_byte),
        .o_valid(w_rx_valid),
        .o_ferr (w_rx_ferr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= P_CMD;
            r_addr      <= '0;
            r_tmo       <= '0;
            r_prog_we   <= 1'b0;
            r_prog_addr <= '0;
            r_prog_data <= '0;
            r_hold      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_addr      <= w_addr_n;
            r_tmo       <= w_tmo_n;
            r_prog_we   <= w_prog_we_n;
            r_prog_addr <= w_prog_addr_n;
            r_prog_data <= w_prog_data_n;
            r_hold      <= w_hold_n;
            r_err       <= w_err_n;
        end
    end

    // Framing errors from the receiver share the single err pulse with protocol errors.
    always_comb begin
        w_state_n     = r_state;
        w_addr_n      = r_addr;
        w_tmo_n       = '0;
        w_prog_we_n   = 1'b0;
        w_prog_addr_n = r_prog_addr;
        w_prog_data_n = r_prog_data;
        w_hold_n      = r_hold;
        w_err_n       = w_rx_ferr;
        case (r_state)
            P_CMD: begin
                if (w_rx_valid) begin
                    if (is_wr_cmd(w_rx_byte)) begin
                        w_addr_n  = w_rx_byte[ADDR_WIDTH-1:0];
                        w_state_n = P_DATA;
                    end else if (w_rx_byte == CMD_HOLD) begin
                        w_hold_n = 1'b1;
                    end else if (w_rx_byte == CMD_RUN) begin
                        w_hold_n = 1'b0;
                    end else begin
                        w_err_n = 1'b1;
                    end
                end
            end
            P_DATA: begin
                if (w_rx_valid) begin
                    w_state_n = P_CMD;
                    if (r_hold) begin
                        w_prog_we_n   = 1'b1;
                        w_prog_addr_n = r_addr;
                        w_prog_data_n = w_rx_byte;
                    end else begin
                        w_err_n = 1'b1;
                    end
                end else if (r_tmo == TW'(TIMEOUT_CLKS - 1)) begin
                    w_err_n   = 1'b1;
                    w_state_n = P_CMD;
                end else begin
                    w_tmo_n = r_tmo + 1'b1;
                end
            end
            default: w_state_n = P_CMD;
        endcase
    end

    assign prog_we   = r_prog_we;
    assign prog_addr = r_prog_addr;
    assign prog_data = r_prog_data;
    assign cpu_hold  = r_hold;
    assign err       = r_err;

`ifdef UART_LOADER_ECHO_EN
    logic       r_cmd_ack;
    logic       w_tx_start;
    logic [7:0] w_tx_byte;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd_ack <= 1'b0;
        end else begin
            r_cmd_ack <= w_rx_valid && (r_state == P_CMD) &&
                         ((w_rx_byte == CMD_HOLD) || (w_rx_byte == CMD_RUN));
        end
    end

    // Write, H/R and err events are mutually exclusive in any one cycle.
    assign w_tx_start = r_prog_we | r_cmd_ack | r_err;
    assign w_tx_byte  = r_err ? NAK : ACK;

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_start(w_tx_start),
        .i_byte (w_tx_byte),
        .o_tx   (usb_tx)
    );
`else
    assign usb_tx = 1'b1;
`endif

endmodule
